axil_regfile_write_slave: RTL and testbench
===========================================

Name: axil_regfile_write_slave

Overview:
Parametrised AXI4-Lite write-channel slave with an integrated register file. It is the successor to the single-register write slave.
- AW and W channels are accepted independently, in either order or in the same cycle.
- Byte-lane strobes are generalised to DATA_WIDTH/8 lanes.
- Writes are decoded into NUM_REGS registers.
- Out-of-range addresses return SLVERR.
- Commit is pipelined against B-channel back-pressure.
The block sits between the AXI4-Lite interconnect and the peripheral control logic, which reads reg_q directly.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, data width; must be 32 or 64
NUM_REGS, 16, number of DATA_WIDTH registers; must be 2..256
BASE_ADDR, 0, byte address of register 0; aligned to DATA_WIDTH/8

Ports:
clk  in  1  clock
resetn  in  1  asynchronous, active-low reset
AW_ADDR  in  ADDR_WIDTH  write address
AW_VALID  in  1  address valid
AW_READY  out  1  address ready
W_DATA  in  DATA_WIDTH  write data
W_STRB  in  DATA_WIDTH/8  byte-lane strobes
W_VALID  in  1  data valid
W_READY  out  1  data ready
B_RESP  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
B_VALID  out  1  response valid
B_READY  in  1  response ready
wr_en  out  1  one-cycle pulse per committed OKAY write
wr_index  out  clog2(NUM_REGS)  register index of the committed write
wr_data  out  DATA_WIDTH  post-merge value written to the register
reg_q  out  NUM_REGS*DATA_WIDTH  flattened register contents; register i at bits [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset is asynchronous, active-low. All outputs, reg_q, and the internal aw_full/w_full flags go to 0: AW_READY=0, W_READY=0, B_VALID=0, B_RESP=0, wr_en=0.
  - A reset mid-transaction discards any held address/data and any pending response; no B handshake follows.
- AW holding register plus flag aw_full.
  - AW_READY = !aw_full, registered; goes 1 the first cycle after reset release.
  - On AW_VALID && AW_READY: capture AW_ADDR, set aw_full; AW_READY drops the next cycle.
- W holding register plus flag w_full, symmetric to AW. Captures W_DATA and W_STRB.
- Commit condition at a rising edge: aw_full && w_full && (!B_VALID || B_READY). At that edge:
  - Clear aw_full and w_full; AW_READY and W_READY return to 1 the following cycle.
  - Set B_VALID=1 and load B_RESP.
  - If the response is OKAY: update the register, set wr_en=1 for exactly one cycle, drive wr_index and wr_data.
  - If the response is SLVERR: wr_en stays 0; wr_index and wr_data hold their previous values.
- Latency: with both handshakes at edge E0, the commit happens at E1. B_VALID, wr_en and the new reg_q are all visible in the cycle after E1.
- A new AW/W may be accepted while B_VALID is pending. Its commit stalls until the B handshake.
  - If B_READY=1 at the same edge the commit condition holds, B_VALID stays 1 with the new response, giving back-to-back commits.
- B_VALID is held, with B_RESP stable, until the edge where B_READY=1; it then clears unless a new commit occurs at that same edge.
- Address decode:
  - offset = AW_ADDR - BASE_ADDR.
  - index = offset >> log2(DATA_WIDTH/8); the low log2(DATA_WIDTH/8) bits are ignored.
  - OKAY if AW_ADDR >= BASE_ADDR and index < NUM_REGS; otherwise SLVERR.
- Strobe merge: byte lane k of the new value = W_STRB[k] ? W_DATA byte k : old register byte k.
  - W_STRB of all zeros is OKAY: wr_en pulses, the register is unchanged, and wr_data equals the old value.
- AW_VALID and W_VALID are never required to arrive in a particular order. Holding a channel's VALID while its flag is full has no effect.

Test Plan:
- AW=BASE+0x0C and W=0xDEADBEEF, STRB=4'hF in the same cycle, B_READY=1 → one cycle later B_VALID=1, B_RESP=00, wr_en=1, wr_index=3, reg 3=0xDEADBEEF.
- AW handshake, then W 3 cycles later → commit exactly 1 cycle after the W handshake. Repeat with W first, AW 3 cycles later → same result.
- Reg 5=0x11223344, then write 0xAABBCCDD with STRB=4'b0101 → reg 5=0x11BB33DD and wr_data=0x11BB33DD. Then STRB=0 → OKAY, reg 5 unchanged.
- AW=BASE+4*NUM_REGS, and separately AW < BASE → B_RESP=10, wr_en=0, all reg_q unchanged.
- Hold B_READY=0 for 5 cycles with a second AW/W presented:
  - Second AW/W accepted, then AW_READY and W_READY both stay 0.
  - First response held stable.
  - On the B_READY edge the second commit follows immediately, with B_VALID staying 1.
- Assert resetn=0 after the AW handshake but before W → all outputs 0; after release, a W-only handshake produces no commit.

Source files
------------

// File: rtl/axil_regfile_write_slave.sv
// AXI4-Lite write slave: NUM_REGS-entry register file, byte-strobe merge, SLVERR outside the window.
// Commit one edge after AW and W are both held; stalls while B is back-pressured and holds both READYs low.
module axil_regfile_write_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [ADDR_WIDTH-1:0]          AW_ADDR,
  input  logic                           AW_VALID,
  output logic                           AW_READY,
  input  logic [DATA_WIDTH-1:0]          W_DATA,
  input  logic [DATA_WIDTH/8-1:0]        W_STRB,
  input  logic                           W_VALID,
  output logic                           W_READY,
  output logic [1:0]                     B_RESP,
  output logic                           B_VALID,
  input  logic                           B_READY,
  output logic                           wr_en,
  output logic [$clog2(NUM_REGS)-1:0]    wr_index,
  output logic [DATA_WIDTH-1:0]          wr_data,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);

  logic                  aw_full, w_full;
  logic                  aw_full_nxt, w_full_nxt;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [ADDR_WIDTH-1:0] offset, word;
  logic                  in_range, commit;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] old_val, new_val;

  // Decode works on the held address, so it is stable for the whole wait for W or for B.
  always_comb begin
    offset   = aw_addr - BASE_ADDR;
    word     = offset >> LSB;
    in_range = (aw_addr >= BASE_ADDR) && (word < ADDR_WIDTH'(NUM_REGS));
    idx      = word[IDX_W-1:0];
    old_val  = regs[idx];
    new_val  = old_val;
    for (int k = 0; k < STRB_W; k++) begin
      if (w_strb[k]) new_val[k*8 +: 8] = w_data[k*8 +: 8];
    end
  end

  always_comb begin
    commit      = aw_full && w_full && (!B_VALID || B_READY);
    aw_full_nxt = aw_full;
    w_full_nxt  = w_full;
    if (commit) begin
      aw_full_nxt = 1'b0;
      w_full_nxt  = 1'b0;
    end else begin
      if (AW_VALID && AW_READY) aw_full_nxt = 1'b1;
      if (W_VALID && W_READY)   w_full_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      AW_READY <= 1'b0;
      W_READY  <= 1'b0;
      aw_addr  <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      B_VALID  <= 1'b0;
      B_RESP   <= 2'b00;
      wr_en    <= 1'b0;
      wr_index <= '0;
      wr_data  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      aw_full  <= aw_full_nxt;
      w_full   <= w_full_nxt;
      AW_READY <= !aw_full_nxt;
      W_READY  <= !w_full_nxt;
      if (AW_VALID && AW_READY) aw_addr <= AW_ADDR;
      if (W_VALID && W_READY) begin
        w_data <= W_DATA;
        w_strb <= W_STRB;
      end
      wr_en <= 1'b0;
      if (commit) begin
        B_VALID <= 1'b1;
        B_RESP  <= in_range ? 2'b00 : 2'b10;
        if (in_range) begin
          regs[idx] <= new_val;
          wr_en     <= 1'b1;
          wr_index  <= idx;
          wr_data   <= new_val;
        end
      end else if (B_READY) begin
        B_VALID <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end
endmodule

// File: tb/tb_axil_regfile_write_slave.sv
// Bench for axil_regfile_write_slave: directed vector table, back-pressure and reset sequences, random writes vs model.
module tb_axil_regfile_write_slave;
  localparam int NR = 16;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [31:0]     AW_ADDR = '0;
  logic            AW_VALID = 1'b0;
  logic            AW_READY;
  logic [31:0]     W_DATA = '0;
  logic [3:0]      W_STRB = '0;
  logic            W_VALID = 1'b0;
  logic            W_READY;
  logic [1:0]      B_RESP;
  logic            B_VALID;
  logic            B_READY = 1'b0;
  logic            wr_en;
  logic [3:0]      wr_index;
  logic [31:0]     wr_data;
  logic [NR*32-1:0] reg_q;

  always #5 clk = ~clk;

  axil_regfile_write_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .resetn(resetn),
    .AW_ADDR(AW_ADDR), .AW_VALID(AW_VALID), .AW_READY(AW_READY),
    .W_DATA(W_DATA), .W_STRB(W_STRB), .W_VALID(W_VALID), .W_READY(W_READY),
    .B_RESP(B_RESP), .B_VALID(B_VALID), .B_READY(B_READY),
    .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data), .reg_q(reg_q)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] mreg [NR];
  logic [3:0]  last_idx = '0;
  logic [31:0] last_val = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string name);
    logic [NR*32-1:0] exp;
    for (int i = 0; i < NR; i++) exp[i*32 +: 32] = mreg[i];
    total++;
    if (reg_q !== exp) begin
      bad++;
      $display("FAIL %s: reg_q got %h want %h", name, reg_q, exp);
    end
  endtask

  // Reference: byte address window check, word index, per-lane merge over the stored value.
  function automatic void model(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                                output logic [1:0] resp, output logic we,
                                output logic [3:0] idx, output logic [31:0] val);
    longint off;
    off  = longint'(addr) - longint'(BASE);
    resp = 2'b10;
    we   = 1'b0;
    idx  = last_idx;
    val  = last_val;
    if (off >= 0 && off / 4 < NR) begin
      idx = 4'(off / 4);
      val = mreg[idx];
      for (int k = 0; k < 4; k++) if (strb[k]) val[k*8 +: 8] = data[k*8 +: 8];
      resp = 2'b00;
      we   = 1'b1;
    end
  endfunction

  task automatic apply_model(input logic we, input logic [3:0] idx, input logic [31:0] val);
    if (we) begin
      mreg[idx] = val;
      last_idx  = idx;
      last_val  = val;
    end
  endtask

  // Drives AW after aw_dly cycles and W after w_dly cycles (negative: channel skipped), then waits for B.
  // lat counts negedges after the last handshake edge until B_VALID is seen; commit one edge later gives 2.
  task automatic xact(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input int aw_dly, input int w_dly,
                      output logic [1:0] resp, output logic we, output logic [3:0] wi,
                      output logic [31:0] wd, output int lat);
    bit aw_done = (aw_dly < 0);
    bit w_done  = (w_dly < 0);
    int cyc = 0;
    lat = -1; resp = 2'b11; we = 1'bx; wi = 'x; wd = 'x;
    B_READY = 1'b1;
    AW_ADDR = addr; W_DATA = data; W_STRB = strb;
    while (!(aw_done && w_done) && cyc < 40) begin
      AW_VALID = !aw_done && (cyc >= aw_dly);
      W_VALID  = !w_done && (cyc >= w_dly);
      @(negedge clk);
      if (AW_VALID && AW_READY) aw_done = 1'b1;
      if (W_VALID && W_READY)   w_done  = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    AW_VALID = 1'b0; W_VALID = 1'b0;
    if (!(aw_done && w_done)) begin
      chk("handshake_timeout", 32'(cyc), 32'd0);
      return;
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (B_VALID) begin
        lat = i; resp = B_RESP; we = wr_en; wi = wr_index; wd = wr_data;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    logic [1:0]  resp;
    logic        we;
    logic [3:0]  idx;
    logic [31:0] val;
  } vec_t;

  vec_t tv [8];

  initial begin
    logic [1:0]  resp, eresp;
    logic        we, ewe;
    logic [3:0]  wi, eidx;
    logic [31:0] wd, eval, addr, data;
    logic [3:0]  strb;
    int          lat;
    bit          hs, seen;

    tv[0] = '{32'h0000_100C, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00, 1'b1, 4'd3,  32'hDEADBEEF};
    tv[1] = '{32'h0000_1014, 32'h11223344, 4'hF, 0, 3, 2'b00, 1'b1, 4'd5,  32'h11223344};
    tv[2] = '{32'h0000_1014, 32'hAABBCCDD, 4'h5, 3, 0, 2'b00, 1'b1, 4'd5,  32'h11BB33DD};
    tv[3] = '{32'h0000_1014, 32'hFFFFFFFF, 4'h0, 1, 1, 2'b00, 1'b1, 4'd5,  32'h11BB33DD};
    tv[4] = '{32'h0000_1040, 32'hFFFFFFFF, 4'hF, 0, 0, 2'b10, 1'b0, 4'd5,  32'h11BB33DD};
    tv[5] = '{32'h0000_0FFC, 32'h12345678, 4'hF, 2, 0, 2'b10, 1'b0, 4'd5,  32'h11BB33DD};
    tv[6] = '{32'h0000_1017, 32'h01020304, 4'hF, 0, 0, 2'b00, 1'b1, 4'd5,  32'h01020304};
    tv[7] = '{32'h0000_103C, 32'hCAFEF00D, 4'h8, 0, 2, 2'b00, 1'b1, 4'd15, 32'hCA000000};
    for (int i = 0; i < NR; i++) mreg[i] = '0;

    #2;
    chk("reset_outputs", 32'({AW_READY, W_READY, B_VALID, B_RESP, wr_en}), 32'd0);
    chk_regs("reset_regs");
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", 32'({AW_READY, W_READY}), 32'b11);

    for (int t = 0; t < 8; t++) begin
      xact(tv[t].addr, tv[t].data, tv[t].strb, tv[t].aw_dly, tv[t].w_dly, resp, we, wi, wd, lat);
      chk($sformatf("vec%0d_lat", t), 32'(lat), 32'd2);
      chk($sformatf("vec%0d_resp", t), 32'(resp), 32'(tv[t].resp));
      chk($sformatf("vec%0d_wr_en", t), 32'(we), 32'(tv[t].we));
      chk($sformatf("vec%0d_wr_index", t), 32'(wi), 32'(tv[t].idx));
      chk($sformatf("vec%0d_wr_data", t), wd, tv[t].val);
      chk($sformatf("vec%0d_wr_en_pulse", t), 32'(wr_en), 32'd0);
      apply_model(tv[t].we, tv[t].idx, tv[t].val);
      chk_regs($sformatf("vec%0d_regs", t));
    end

    // Back-pressure: SLVERR response held while a second write (reg 2) is taken and stalled.
    B_READY = 1'b0;
    AW_ADDR = 32'h0000_2000; W_DATA = 32'h0; W_STRB = 4'hF;
    AW_VALID = 1'b1; W_VALID = 1'b1;
    @(negedge clk);
    chk("bp_ready_idle", 32'({AW_READY, W_READY}), 32'b11);
    @(posedge clk); #1;
    AW_ADDR = BASE + 32'd8; W_DATA = 32'h55AA55AA;
    hs = 1'b0;
    for (int i = 0; i < 10 && !hs; i++) begin
      @(negedge clk);
      hs = AW_READY && W_READY;
      @(posedge clk); #1;
    end
    AW_VALID = 1'b0; W_VALID = 1'b0;
    chk("bp_second_accepted", 32'(hs), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", i), 32'({B_VALID, B_RESP, AW_READY, W_READY, wr_en}), 32'b110000);
      @(posedge clk); #1;
    end
    model(BASE + 32'd8, 32'h55AA55AA, 4'hF, eresp, ewe, eidx, eval);
    B_READY = 1'b1;
    @(posedge clk); #1;
    B_READY = 1'b0;
    @(negedge clk);
    chk("bp_b2b_valid_resp", 32'({B_VALID, B_RESP}), 32'({1'b1, eresp}));
    chk("bp_b2b_wr_en", 32'(wr_en), 32'(ewe));
    chk("bp_b2b_wr_index", 32'(wr_index), 32'(eidx));
    chk("bp_b2b_wr_data", wr_data, eval);
    apply_model(ewe, eidx, eval);
    B_READY = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_b_cleared", 32'(B_VALID), 32'd0);
    chk_regs("bp_regs");
    @(posedge clk); #1;

    // Reset after AW handshake: held address discarded, lone W must not commit.
    AW_ADDR = BASE + 32'd4; AW_VALID = 1'b1;
    @(posedge clk); #1;
    AW_VALID = 1'b0;
    #1 resetn = 1'b0;
    #1;
    chk("mid_reset_outputs", 32'({AW_READY, W_READY, B_VALID, B_RESP, wr_en, wr_index}), 32'd0);
    chk("mid_reset_wr_data", wr_data, 32'd0);
    for (int i = 0; i < NR; i++) mreg[i] = '0;
    last_idx = '0; last_val = '0;
    chk_regs("mid_reset_regs");
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    W_DATA = 32'h77777777; W_STRB = 4'hF; W_VALID = 1'b1;
    hs = 1'b0;
    for (int i = 0; i < 10 && !hs; i++) begin
      @(negedge clk);
      hs = W_READY;
      @(posedge clk); #1;
    end
    W_VALID = 1'b0;
    chk("w_only_accepted", 32'(hs), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (B_VALID || wr_en) seen = 1'b1;
    end
    chk("w_only_no_commit", 32'(seen), 32'd0);
    @(posedge clk); #1;
    model(BASE + 32'd4, 32'h77777777, 4'hF, eresp, ewe, eidx, eval);
    xact(BASE + 32'd4, 32'h0, 4'h0, 0, -1, resp, we, wi, wd, lat);
    chk("late_aw_lat", 32'(lat), 32'd2);
    chk("late_aw_wr_data", wd, eval);
    chk("late_aw_wr_index", 32'(wi), 32'(eidx));
    apply_model(ewe, eidx, eval);
    chk_regs("late_aw_regs");

    // Random writes around and across the register window.
    for (int n = 0; n < 40; n++) begin
      addr = BASE - 32'd8 + 32'($urandom_range(0, 4 * NR + 15));
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      model(addr, data, strb, eresp, ewe, eidx, eval);
      xact(addr, data, strb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), resp, we, wi, wd, lat);
      chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'd2);
      chk($sformatf("rnd%0d_resp", n), 32'({resp, we}), 32'({eresp, ewe}));
      chk($sformatf("rnd%0d_wr", n), 32'(wi), 32'(eidx));
      chk($sformatf("rnd%0d_wr_data", n), wd, eval);
      apply_model(ewe, eidx, eval);
      chk_regs($sformatf("rnd%0d_regs", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
